// File: rtl/uart_packet_rx_if.sv
// Byte-stream bundle around the packet framer: strobed input from the UART
// receiver and the valid/ready payload output toward the input loader.
interface uart_packet_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport slave  (input  rx_data, rx_valid, out_ready,
                  output out_data, out_valid, out_last);
  modport master (output rx_data, rx_valid, out_ready,
                  input  out_data, out_valid, out_last);
endinterface

// File: rtl/uart_packet_rx.sv
// Parses SOF/LEN/PAYLOAD/CHK frames from the UART byte strobe, buffers the
// payload and releases it on a valid/ready stream only after the checksum verifies.
module uart_packet_rx #(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF            = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 12000
) (
  input  logic             clk,
  input  logic             rst,
  uart_packet_rx_if.slave  bus,
  output logic [7:0]       pkt_ok_cnt,
  output logic             chk_err,
  output logic             len_err,
  output logic             timeout,
  output logic             overrun,
  output logic             busy
);
  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_SEND} state_e;

  state_e           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       acc_q, acc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TO_W-1:0]  tmr_q, tmr_d;
  logic [7:0]       pkt_ok_cnt_q, pkt_ok_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             chk_err_q, chk_err_d;
  logic             len_err_q, len_err_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;

  logic [7:0]       mem_q [MAX_LEN];
  logic             mem_we;
  logic [7:0]       sum8;
  logic             timed, tmr_hit, hs;

  assign sum8    = acc_q + bus.rx_data;
  assign timed   = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign tmr_hit = (tmr_q == TO_W'(TIMEOUT_CYCLES));
  assign hs      = out_valid_q && bus.out_ready;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    acc_d        = acc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pkt_ok_cnt_d = pkt_ok_cnt_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    chk_err_d    = 1'b0;
    len_err_d    = 1'b0;
    timeout_d    = 1'b0;
    overrun_d    = 1'b0;
    mem_we       = 1'b0;
    // Silence counter restarts on entry to a timed state and on every byte.
    tmr_d        = timed ? tmr_q + TO_W'(1) : '0;
    if (timed && bus.rx_valid) tmr_d = '0;

    case (state_q)
      S_IDLE: if (bus.rx_valid && bus.rx_data == SOF) state_d = S_LEN;
      S_LEN: begin
        if (bus.rx_valid) begin
          len_d = bus.rx_data;
          acc_d = bus.rx_data;
          if (bus.rx_data > 8'(MAX_LEN)) begin
            len_err_d = 1'b1;
            state_d   = S_IDLE;
          end else if (bus.rx_data == 8'd0) begin
            state_d = S_CHK;
          end else begin
            wr_ptr_d = '0;
            state_d  = S_PAYLOAD;
          end
        end else if (tmr_hit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          acc_d    = sum8;
          if (8'(wr_ptr_q) == len_q - 8'd1) state_d = S_CHK;
        end else if (tmr_hit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_CHK: begin
        if (bus.rx_valid) begin
          if (sum8 == 8'd0) begin
            pkt_ok_cnt_d = pkt_ok_cnt_q + 8'd1;
            if (len_q != 8'd0) begin
              state_d     = S_SEND;
              rd_ptr_d    = '0;
              out_valid_d = 1'b1;
              out_last_d  = (len_q == 8'd1);
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            chk_err_d = 1'b1;
            state_d   = S_IDLE;
          end
        end else if (tmr_hit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_SEND: begin
        // No backpressure toward the receiver: bytes arriving here are lost.
        overrun_d = bus.rx_valid;
        if (hs) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (out_last_q) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            out_last_d = (8'(rd_ptr_q) + 8'd2 == len_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      acc_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tmr_q        <= '0;
      pkt_ok_cnt_q <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      chk_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tmr_q        <= tmr_d;
      pkt_ok_cnt_q <= pkt_ok_cnt_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      chk_err_q    <= chk_err_d;
      len_err_q    <= len_err_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign pkt_ok_cnt    = pkt_ok_cnt_q;
  assign chk_err       = chk_err_q;
  assign len_err       = len_err_q;
  assign timeout       = timeout_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_packet_rx.sv
// Scoreboard bench for the packet framer: expected payload bytes are queued as
// frames are sent and popped by a handshake monitor.
module tb_uart_packet_rx;
  localparam int TO = 12000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_packet_rx_if bus();
  logic [7:0] pkt_ok_cnt;
  logic       chk_err, len_err, timeout, overrun, busy;

  uart_packet_rx #(.MAX_LEN(16), .SOF(8'hAA), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pkt_ok_cnt(pkt_ok_cnt),
    .chk_err(chk_err), .len_err(len_err), .timeout(timeout),
    .overrun(overrun), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];
  logic [8:0] exp_e;
  logic [7:0] exp_cnt = 8'd0;
  int n_out = 0, n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0;

  // Handshake monitor and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_err) n_chk++;
      if (len_err) n_len++;
      if (timeout) n_to++;
      if (overrun) n_ovr++;
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got data=%h last=%b, none expected", bus.out_data, bus.out_last);
        end else begin
          exp_e = exp_q.pop_front();
          if ({bus.out_last, bus.out_data} !== exp_e) begin
            errors++;
            $display("FAIL out_byte got last=%b data=%h, expected last=%b data=%h",
                     bus.out_last, bus.out_data, exp_e[8], exp_e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // AA 03 11 22 33 97: a valid three-byte frame.
  task automatic frame_123();
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    exp_cnt = exp_cnt + 8'd1;
    send_byte(8'hAA); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h97);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && k < 200) begin idle(1); k++; end
    checks++;
    if (exp_q.size() != 0 || bus.out_valid) begin
      errors++;
      $display("FAIL %s drain got %0d bytes pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.out_ready = 1'b1;
    rst = 1'b1;
    idle(2);
    checks++;
    if ({busy, bus.out_valid, bus.out_last, chk_err, len_err, timeout, overrun} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b, expected 0000000",
               {busy, bus.out_valid, bus.out_last, chk_err, len_err, timeout, overrun});
    end
    checks++;
    if (pkt_ok_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d, expected 0", pkt_ok_cnt); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    int o0, e0;
    o0 = n_out; e0 = n_chk + n_len + n_to + n_ovr;
    bus.out_ready = 1'b1;
    frame_123();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid cycle %0d got %b, expected 1", i, bus.out_valid); end
      idle(1);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_end got valid=%b, expected 0", bus.out_valid); end
    checks++;
    if (n_out - o0 != 3) begin errors++; $display("FAIL basic_count got %0d bytes, expected 3", n_out - o0); end
    checks++;
    if (pkt_ok_cnt !== exp_cnt) begin errors++; $display("FAIL basic_pkt got %0d, expected %0d", pkt_ok_cnt, exp_cnt); end
    checks++;
    if (n_chk + n_len + n_to + n_ovr != e0) begin errors++; $display("FAIL basic_pulses got %0d, expected %0d", n_chk + n_len + n_to + n_ovr, e0); end
  endtask

  task automatic test_chk_err();
    int o0, c0;
    o0 = n_out; c0 = n_chk;
    send_byte(8'hAA); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h98);
    checks++;
    if (chk_err !== 1'b1) begin errors++; $display("FAIL chk_pulse got %b, expected 1", chk_err); end
    idle(4);
    checks++;
    if (n_chk - c0 != 1) begin errors++; $display("FAIL chk_count got %0d, expected 1", n_chk - c0); end
    checks++;
    if (n_out != o0 || pkt_ok_cnt !== exp_cnt || busy !== 1'b0) begin
      errors++;
      $display("FAIL chk_no_out got out=%0d cnt=%0d busy=%b, expected out=%0d cnt=%0d busy=0",
               n_out, pkt_ok_cnt, busy, o0, exp_cnt);
    end
    frame_123();
    wait_drain("chk_retry");
    checks++;
    if (pkt_ok_cnt !== exp_cnt) begin errors++; $display("FAIL chk_retry_pkt got %0d, expected %0d", pkt_ok_cnt, exp_cnt); end
  endtask

  task automatic test_zero_len_and_len_err();
    int o0, l0;
    o0 = n_out; l0 = n_len;
    send_byte(8'h55);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_55 got busy=%b, expected 0", busy); end
    send_byte(8'hAA); send_byte(8'h00);
    exp_cnt = exp_cnt + 8'd1;
    send_byte(8'h00);
    idle(3);
    checks++;
    if (pkt_ok_cnt !== exp_cnt || n_out != o0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len got cnt=%0d out=%0d busy=%b, expected cnt=%0d out=%0d busy=0",
               pkt_ok_cnt, n_out, busy, exp_cnt, o0);
    end
    send_byte(8'hAA); send_byte(8'h11);
    checks++;
    if (len_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len_err got len_err=%b busy=%b, expected 1 0", len_err, busy);
    end
    idle(2);
    checks++;
    if (n_len - l0 != 1) begin errors++; $display("FAIL len_err_count got %0d, expected 1", n_len - l0); end
  endtask

  task automatic test_timeout();
    int first, t0;
    bit early;
    t0 = n_to;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
    first = -1;
    for (int k = 1; k <= TO + 5; k++) begin
      idle(1);
      if (timeout && first < 0) first = k;
    end
    checks++;
    if (first != TO + 1) begin errors++; $display("FAIL timeout_cycle got %0d, expected %0d", first, TO + 1); end
    checks++;
    if (n_to - t0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_once got %0d pulses busy=%b, expected 1 0", n_to - t0, busy);
    end
    // Bytes just before and exactly at the limit keep the frame alive.
    t0 = n_to;
    early = 1'b0;
    bus.out_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    exp_cnt = exp_cnt + 8'd1;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
    idle(TO - 1);
    send_byte(8'h22);
    idle(TO);
    if (busy !== 1'b1) early = 1'b1;
    send_byte(8'hCB);
    wait_drain("timeout_race");
    checks++;
    if (n_to != t0 || early) begin errors++; $display("FAIL timeout_race got %0d pulses early=%b, expected 0 0", n_to - t0, early); end
    checks++;
    if (pkt_ok_cnt !== exp_cnt) begin errors++; $display("FAIL timeout_race_pkt got %0d, expected %0d", pkt_ok_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure_overrun();
    int v0;
    bit bad;
    v0 = n_ovr;
    bad = 1'b0;
    bus.out_ready = 1'b0;
    frame_123();
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 || bus.out_last !== 1'b0) bad = 1'b1;
      if (i == 5) send_byte(8'hAA); else idle(1);
    end
    checks++;
    if (bad) begin errors++; $display("FAIL stall_hold got unstable output, expected data 11 held"); end
    checks++;
    if (n_ovr - v0 != 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun got %0d pulses busy=%b, expected 1 1", n_ovr - v0, busy);
    end
    bus.out_ready = 1'b1;
    wait_drain("stall_release");
    frame_123();
    wait_drain("after_overrun");
    checks++;
    if (pkt_ok_cnt !== exp_cnt) begin errors++; $display("FAIL overrun_pkt got %0d, expected %0d", pkt_ok_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
    rst = 1'b1; idle(1); rst = 1'b0;
    exp_cnt = 8'd0;
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || pkt_ok_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_payload got busy=%b valid=%b cnt=%0d, expected 0 0 0", busy, bus.out_valid, pkt_ok_cnt);
    end
    bus.out_ready = 1'b0;
    frame_123();
    idle(3);
    rst = 1'b1; idle(1); rst = 1'b0;
    exp_q.delete();
    exp_cnt = 8'd0;
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || pkt_ok_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_send got busy=%b valid=%b cnt=%0d, expected 0 0 0", busy, bus.out_valid, pkt_ok_cnt);
    end
    bus.out_ready = 1'b1;
    frame_123();
    wait_drain("after_reset");
    checks++;
    if (pkt_ok_cnt !== 8'd1) begin errors++; $display("FAIL rst_recover_pkt got %0d, expected 1", pkt_ok_cnt); end
  endtask

  initial begin
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_chk_err();
    test_zero_len_and_len_err();
    test_timeout();
    test_backpressure_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_packet_rx.md
Name: uart_packet_rx

Overview:
Framing stage directly downstream of the UART receiver in the uart_echo design. It consumes the received byte strobe stream and parses frames of the form SOF, LEN, PAYLOAD[LEN], CHK. It buffers the payload and releases it on a valid/ready byte stream only after the checksum verifies. The output feeds the network's input loader instead of the echo path; pkt_ok_cnt and error pulses drive board LEDs.

Parameters:
MAX_LEN, 16, maximum payload bytes; the buffer depth.
SOF, 8'hAA, start-of-frame byte.
TIMEOUT_CYCLES, 12000, clk cycles of inter-byte silence (1 ms at 12 MHz) that abort a frame.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
rx_data  in  8  byte from UART receiver; valid only when rx_valid=1.
rx_valid  in  1  single-cycle strobe per received byte; no backpressure to the receiver.
out_data  out  8  payload byte.
out_valid  out  1  out_data valid.
out_ready  in  1  consumer accepts the byte when out_valid and out_ready are both 1.
out_last  out  1  marks the final payload byte; qualified by out_valid.
pkt_ok_cnt  out  8  count of checksum-verified frames; wraps 255->0.
chk_err  out  1  one-cycle pulse: checksum mismatch.
len_err  out  1  one-cycle pulse: LEN > MAX_LEN.
timeout  out  1  one-cycle pulse: frame aborted by inter-byte silence.
overrun  out  1  one-cycle pulse: byte received while in SEND and dropped.
busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; out_valid, out_last, all pulses, busy = 0; pkt_ok_cnt = 0; pointers, length and checksum accumulator = 0. Reset aborts any frame or SEND in progress immediately. Buffer contents are don't-care.
- FSM states: IDLE, LEN, PAYLOAD, CHK, SEND.
- IDLE: a byte equal to SOF moves to LEN. Other bytes are ignored silently.
- LEN:
  - A byte > MAX_LEN pulses len_err and returns to IDLE.
  - A byte = 0 moves to CHK.
  - Otherwise the length is latched, the write pointer is cleared, and the state moves to PAYLOAD.
  - The accumulator is initialised to the LEN byte.
- PAYLOAD: each byte is written to buf[wr_ptr], wr_ptr increments, and the byte is added to the accumulator mod 256. After byte number LEN the state moves to CHK.
- CHK:
  - If (acc + byte) mod 256 == 0, pkt_ok_cnt increments. The next state is SEND if LEN > 0, else IDLE.
  - On mismatch, chk_err pulses and the state returns to IDLE; nothing is output.
- SEND:
  - out_valid = 1 starting the cycle after the CHK byte is accepted.
  - out_data = buf[rd_ptr], with rd_ptr starting at 0.
  - out_last = (rd_ptr == LEN-1).
  - On each handshake rd_ptr increments. The handshake on the last byte returns the state to IDLE, so out_valid = 0 on the next cycle.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
- Overrun: rx_valid in SEND drops the byte and pulses overrun. The byte is not parsed, even if it equals SOF.
- Timeout:
  - A counter runs in LEN, PAYLOAD and CHK. It clears on entry to these states and on every rx_valid.
  - When it reaches TIMEOUT_CYCLES, timeout pulses and the state returns to IDLE.
  - If rx_valid arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the byte wins and no timeout occurs.
  - SEND has no timeout and waits indefinitely for out_ready.
- Pulse outputs are registered, assert one cycle after the causing byte, and are mutually exclusive per byte.
- Widths: LEN is compared as 8 bits. Pointers are clog2(MAX_LEN) bits. The timeout counter is clog2(TIMEOUT_CYCLES+1) bits. All checksum arithmetic is 8-bit wrap.

Test Plan:
1. Bytes AA 03 11 22 33 97 with out_ready=1 -> out_data 11, 22, 33 on consecutive cycles, out_last on 33 only; pkt_ok_cnt=1; no error pulses.
2. Bytes AA 03 11 22 33 98 -> chk_err pulses once; out_valid never asserts; pkt_ok_cnt unchanged. Then the case-1 bytes -> accepted normally.
3. Bytes 55 AA 00 00, then AA 11 -> the 55 is ignored; the zero-length frame increments pkt_ok_cnt with no output; AA 11 (LEN=17) pulses len_err and busy drops.
4. Bytes AA 02 11, then idle for 12000 cycles -> timeout pulses exactly once and the FSM is in IDLE. Repeat with a byte arriving at cycle 11999 -> no timeout.
5. Case-1 frame with out_ready=0 for 20 cycles, then 1; a byte AA arrives during SEND -> out_data holds 11 stably; overrun pulses; then 11, 22, 33 are delivered and the following frame parses normally.
6. rst asserted mid-PAYLOAD and mid-SEND -> next cycle: busy=0, out_valid=0, pkt_ok_cnt=0. A subsequent valid frame is accepted.
